// File: rtl/y86_mem_arbiter.sv
// Two-port (fetch / data) arbiter that turns 64-bit little-endian accesses
// into eight byte cycles on a single-ported byte RAM, with span range checking.
//
// state  | meaning
// IDLE   | arbitrate; grant pulses combinationally, request fields latched
// ACCESS | one byte per cycle, cnt 0..7
// WAIT   | reads only: collect the last byte from the RAM's 1-cycle latency
// DONE   | done/err pulse to the granted port
module y86_mem_arbiter #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [63:0]       if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [63:0]       if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [63:0]       dm_addr,
  input  logic [63:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [63:0]       dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [63:0] LAST_BASE = 64'(MEM_SIZE - 8);

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        cntPrev;
  logic [ADDR_W-1:0] base;
  logic              we;
  logic [63:0]       wdata;
  logic              owner;      // 0 = fetch, 1 = data
  logic              err;
  logic              lastGrant;  // 0 = fetch, 1 = data
  logic [63:0]       ifRdataQ;
  logic [63:0]       dmRdataQ;
  logic              pickIf;
  logic              pickDm;
  logic [63:0]       selAddr;
  logic              selErr;
  logic              active;

  assign active  = !rst;
  assign cntPrev = cnt - 3'd1;

  always_comb begin
    pickIf = 1'b0;
    pickDm = 1'b0;
    if (active && state == IDLE) begin
      if (if_req && dm_req) begin
        pickIf = lastGrant;
        pickDm = !lastGrant;
      end else begin
        pickIf = if_req;
        pickDm = dm_req;
      end
    end
  end

  // Full 64-bit compare so a base near 2**64 cannot wrap its span into range.
  assign selAddr = pickDm ? dm_addr : if_addr;
  assign selErr  = selAddr > LAST_BASE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      base      <= '0;
      we        <= 1'b0;
      wdata     <= 64'd0;
      owner     <= 1'b0;
      err       <= 1'b0;
      lastGrant <= 1'b1;
      ifRdataQ  <= 64'd0;
      dmRdataQ  <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pickIf || pickDm) begin
            owner     <= pickDm;
            lastGrant <= pickDm;
            we        <= pickDm && dm_we;
            wdata     <= pickDm ? dm_wdata : 64'd0;
            base      <= selAddr[ADDR_W-1:0];
            err       <= selErr;
            cnt       <= 3'd0;
            if (pickDm) dmRdataQ <= 64'd0;
            else        ifRdataQ <= 64'd0;
            state     <= selErr ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          if (!we && cnt != 3'd0) begin
            if (owner) dmRdataQ[{cntPrev, 3'b000} +: 8] <= mem_rdata;
            else       ifRdataQ[{cntPrev, 3'b000} +: 8] <= mem_rdata;
          end
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= we ? DONE : WAIT;
        end
        WAIT: begin
          if (owner) dmRdataQ[63:56] <= mem_rdata;
          else       ifRdataQ[63:56] <= mem_rdata;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low during a reset cycle so an aborted write stops at once.
  assign if_gnt    = pickIf;
  assign dm_gnt    = pickDm;
  assign if_done   = active && state == DONE && !owner;
  assign dm_done   = active && state == DONE && owner;
  assign if_err    = if_done && err;
  assign dm_err    = dm_done && err;
  assign if_rdata  = active ? ifRdataQ : 64'd0;
  assign dm_rdata  = active ? dmRdataQ : 64'd0;
  assign mem_en    = active && state == ACCESS;
  assign mem_we    = mem_en && we;
  assign mem_addr  = mem_en ? base + ADDR_W'(cnt) : '0;
  assign mem_wdata = mem_we ? wdata[{cnt, 3'b000} +: 8] : 8'd0;
  assign busy      = active && state != IDLE;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter: behavioural byte RAM, reference memory image,
// and scoreboards for done pulses and byte writes.
module tb_y86_mem_arbiter;
  localparam int MEM_SIZE = 1024;
  localparam int ADDR_W   = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [63:0]       if_addr = 64'd0;
  logic              if_gnt, if_done, if_err;
  logic [63:0]       if_rdata;
  logic              dm_req = 1'b0, dm_we = 1'b0;
  logic [63:0]       dm_addr = 64'd0, dm_wdata = 64'd0;
  logic              dm_gnt, dm_done, dm_err;
  logic [63:0]       dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  y86_mem_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram    [MEM_SIZE];
  logic [7:0] refMem [MEM_SIZE];

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  typedef struct { bit isData; logic [63:0] rdata; bit err; int doneCyc; } done_t;
  typedef struct { logic [ADDR_W-1:0] a; logic [7:0] d; int c; } wr_t;
  done_t doneQ[$];
  wr_t   wrQ[$];
  done_t de;
  wr_t   wexp;

  int nCmp = 0;
  int nErr = 0;
  bit noMem = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: done pulses and byte writes are popped as the DUT produces them.
  always @(negedge clk) begin
    if (if_done || dm_done) begin
      if (doneQ.size() == 0) chk("spurious_done", 64'({if_done, dm_done}), 64'd0);
      else begin
        de = doneQ.pop_front();
        chk("done_port", 64'(dm_done), 64'(de.isData));
        chk("done_single", 64'(if_done && dm_done), 64'd0);
        chk("done_cycle", 64'(cyc), 64'(de.doneCyc));
        chk("done_rdata", de.isData ? dm_rdata : if_rdata, de.rdata);
        chk("done_err", 64'(de.isData ? dm_err : if_err), 64'(de.err));
      end
    end
    if (mem_en && mem_we) begin
      if (wrQ.size() == 0) chk("spurious_write", 64'(mem_addr), 64'hFFFF);
      else begin
        wexp = wrQ.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(wexp.a));
        chk("wr_data", 64'(mem_wdata), 64'(wexp.d));
        chk("wr_cycle", 64'(cyc), 64'(wexp.c));
      end
    end
    if (noMem) chk("no_mem_activity", 64'(mem_en), 64'd0);
  end

  task automatic pushExpect(input bit isData, input bit wr, input logic [63:0] addr,
                            input logic [63:0] wd, input int g, input int nBytes,
                            input bit pushDone);
    done_t d;
    wr_t   w;
    bit    e;
    int    b;
    e = addr > 64'(MEM_SIZE - 8);
    b = int'(addr[ADDR_W-1:0]);
    d.isData  = isData;
    d.err     = e;
    d.rdata   = 64'd0;
    d.doneCyc = g + (e ? 1 : (wr ? 9 : 10));
    if (!e && !wr)
      for (int i = 0; i < 8; i++) d.rdata[8*i +: 8] = refMem[b + i];
    if (pushDone) doneQ.push_back(d);
    if (!e && wr) begin
      for (int i = 0; i < nBytes; i++) begin
        w.a = ADDR_W'(b + i);
        w.d = wd[8*i +: 8];
        w.c = g + 1 + i;
        wrQ.push_back(w);
        refMem[b + i] = wd[8*i +: 8];
      end
    end
  endtask

  // Entered just after a rising edge; returns just after the edge following the grant.
  task automatic startReq(input bit isData, input bit wr, input logic [63:0] addr,
                          input logic [63:0] wd, input int nBytes, input bit pushDone,
                          output int gCyc);
    if (isData) begin
      dm_req = 1'b1; dm_we = wr; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    gCyc = -1;
    for (int k = 0; k < 30 && gCyc < 0; k++) begin
      @(negedge clk);
      if (isData ? dm_gnt : if_gnt) gCyc = cyc;
    end
    chk("gnt_seen", 64'(gCyc >= 0), 64'd1);
    if (gCyc >= 0) begin
      chk("gnt_other_low", 64'(isData ? if_gnt : dm_gnt), 64'd0);
      pushExpect(isData, wr, addr, wd, gCyc, nBytes, pushDone);
    end
    @(posedge clk); #1;
    if (isData) begin
      dm_req = 1'b0; dm_we = 1'($urandom); dm_addr = {$urandom, $urandom};
      dm_wdata = {$urandom, $urandom};
    end else begin
      if_req = 1'b0; if_addr = {$urandom, $urandom};
    end
  endtask

  task automatic waitIdle();
    bit drained;
    drained = 1'b0;
    for (int k = 0; k < 40 && !drained; k++) begin
      @(negedge clk);
      if (doneQ.size() == 0 && wrQ.size() == 0 && !busy) drained = 1'b1;
    end
    chk("drain_timeout", 64'(doneQ.size() + wrQ.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int g;
    int n;
    int prevG;
    for (int i = 0; i < MEM_SIZE; i++) begin
      ram[i]    = 8'((i * 37 + 5) & 255);
      refMem[i] = 8'((i * 37 + 5) & 255);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 64'(|{if_gnt, if_done, if_rdata, if_err, dm_gnt, dm_done, dm_rdata,
                               dm_err, mem_en, mem_we, mem_addr, mem_wdata, busy}), 64'd0);
    @(posedge clk); #1;

    // Write then read back through the other port.
    startReq(1'b1, 1'b1, 64'h100, 64'h1122334455667788, 8, 1'b1, g);
    waitIdle();
    startReq(1'b0, 1'b0, 64'h100, 64'd0, 8, 1'b1, g);
    waitIdle();
    chk("if_rdata_value", if_rdata, 64'h1122334455667788);

    // Boundary: last legal base vs one past it, and a wrapping fetch address.
    noMem = 1'b1;
    startReq(1'b1, 1'b0, 64'd1017, 64'd0, 8, 1'b1, g);
    waitIdle();
    noMem = 1'b0;
    startReq(1'b1, 1'b0, 64'd1016, 64'd0, 8, 1'b1, g);
    waitIdle();
    startReq(1'b1, 1'b1, 64'd1016, 64'hDEADBEEF_CAFEF00D, 8, 1'b1, g);
    waitIdle();
    startReq(1'b0, 1'b0, 64'd1016, 64'd0, 8, 1'b1, g);
    waitIdle();
    chk("dm_rdata_after_write", dm_rdata, 64'd0);
    noMem = 1'b1;
    startReq(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 8, 1'b1, g);
    waitIdle();
    noMem = 1'b0;

    // Round-robin under a tie right after reset: F, D, F, D.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    if_req = 1'b1; if_addr = 64'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h208;
    n = 0;
    prevG = 0;
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        chk("tie_order", 64'(dm_gnt), 64'(n % 2));
        chk("tie_single", 64'(if_gnt && dm_gnt), 64'd0);
        if (n > 0) chk("tie_spacing", 64'(cyc - prevG), 64'd11);
        prevG = cyc;
        pushExpect(dm_gnt, 1'b0, dm_gnt ? dm_addr : if_addr, 64'd0, cyc, 8, 1'b1);
        n++;
      end
    end
    chk("tie_count", 64'(n), 64'd4);
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    waitIdle();

    // Reset while byte 3 of a write is due: three bytes land, no done pulse.
    startReq(1'b1, 1'b1, 64'h200, 64'hA1A2A3A4A5A6A7A8, 3, 1'b0, g);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'(|{if_gnt, if_done, if_rdata, if_err, dm_gnt, dm_done, dm_rdata,
                               dm_err, mem_en, mem_we, mem_addr, mem_wdata, busy}), 64'd0);
    repeat (12) @(negedge clk);
    chk("abort_writes_left", 64'(wrQ.size()), 64'd0);
    @(posedge clk); #1;
    startReq(1'b0, 1'b0, 64'h200, 64'd0, 8, 1'b1, g);
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/y86_mem_arbiter.md
Name: y86_mem_arbiter

Overview:
- Sequences 64-bit little-endian accesses onto a single-ported, byte-wide memory of MEM_SIZE bytes.
- Shares that memory between two requesters:
  - the instruction-fetch port (read-only);
  - the data-memory port (read/write).
- Each 64-bit access takes 8 byte cycles. Out-of-range spans are rejected with an error flag and never touch memory.
- Sits between the fetch/memory stages and the byte RAM.

Parameters:
- MEM_SIZE, 1024: memory size in bytes.
- ADDR_W, 10: width of the backend byte address; must satisfy 2**ADDR_W >= MEM_SIZE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request (level).
- if_addr  in  64  fetch byte address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted and if_addr sampled.
- if_done  out  1  one-cycle pulse: fetch access complete.
- if_rdata  out  64  fetch read data; valid when if_done=1.
- if_err  out  1  valid with if_done; 1 means the address was out of range.
- dm_req  in  1  data request (level).
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  64  data byte address.
- dm_wdata  in  64  write data.
- dm_gnt  out  1  one-cycle pulse: data request accepted; dm_we, dm_addr and dm_wdata sampled.
- dm_done  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  64  data read data; valid when dm_done=1 and dm_we was 0.
- dm_err  out  1  valid with dm_done; out-of-range flag.
- mem_en  out  1  byte memory enable.
- mem_we  out  1  byte write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte write data.
- mem_rdata  in  8  byte read data, returned 1 cycle after an mem_en=1, mem_we=0 cycle.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=1 at a clock edge), including mid-transaction:
  - state goes to IDLE; all outputs read 0; rdata registers clear; last_grant is set to DATA.
  - No done pulse is produced for an aborted access.
  - Bytes already written by an aborted write remain in memory.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Arbitration applies only when both requests are high. Round-robin: the requester not in last_grant wins, so after reset fetch wins the first tie.
  - A single requester always wins.
  - Winner: gnt pulses this cycle. The arbiter latches base address, we (fetch forces we=0) and wdata, and updates last_grant.
  - Range check: error if addr > MEM_SIZE-8 (the full 8-byte span must fit). On error go to DONE with err=1; otherwise go to ACCESS with cnt=0.
- ACCESS:
  - Drive mem_en=1, mem_we=we, mem_addr = base + cnt (low ADDR_W bits), mem_wdata = wdata[8*cnt+7 : 8*cnt].
  - Read capture: at cnt>=1, mem_rdata goes into byte cnt-1 of the rdata register.
  - cnt increments each cycle. At cnt=7: next state is WAIT for a read, DONE for a write.
- WAIT (reads only): mem_en=0; capture mem_rdata into byte 7; next state DONE.
- DONE:
  - Pulse the granted port's done for one cycle, with err as computed.
  - rdata is the assembled little-endian value on a successful read; it is 0 on error or write.
  - rdata holds its value until that port's next gnt.
  - Next state IDLE.
- Latency, counted from the gnt cycle (gnt = cycle 0):
  - read: done at cycle 10;
  - write: done at cycle 9, with the last byte written at cycle 8;
  - error: done at cycle 1.
- Request handshake:
  - addr, we and wdata are sampled only in the gnt cycle and may change afterwards.
  - A requester that keeps req high after gnt is treated as making a new request once the arbiter is back in IDLE (back-to-back).
  - There is no gnt while busy=1.
- Arithmetic:
  - Range check uses the full 64 bits, so the +7 span cannot wrap.
  - mem_addr is truncated to ADDR_W bits only after the range check passes.
- mem_en=0 in IDLE, WAIT and DONE; mem_we=0 whenever mem_en=0.

Test Plan:
- Reset, then dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0x1122334455667788 -> dm_gnt at cycle 0; mem_wdata bytes 0x88,0x77,…,0x11 to addresses 0x100–0x107 in cycles 1–8; dm_done=1 at cycle 9 with dm_err=0.
- if_req=1, if_addr=0x100 after the previous write -> if_done at cycle 10 with if_rdata=0x1122334455667788 and if_err=0.
- if_req and dm_req both rise in the same IDLE cycle after reset -> fetch is granted first; data is granted in the first IDLE after fetch's DONE; with both held high, grants alternate F, D, F, D.
- dm_addr=1017 (MEM_SIZE-7) -> dm_done at cycle 1 with dm_err=1, dm_rdata=0, and mem_en=0 throughout; dm_addr=1016 -> normal access, dm_err=0.
- if_addr=0xFFFFFFFFFFFFFFFC -> if_err=1 (no wrap into range), no memory activity.
- Assert rst at cycle 4 of a write to 0x200 -> busy=0, all outputs 0 next cycle, no dm_done; bytes 0x200–0x202 updated, 0x203–0x207 unchanged.
